// File: rtl/pipe_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_issue_ctrl_if
// Description : Fetch handshake plus per-stage status/control bundle for the
//               4-stage issue controller. The controller takes the slave side.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_issue_ctrl_if #(
  parameter int CNT_W = 8
) ();
  logic             instr_valid;
  logic [7:0]       instr;
  logic             instr_ready;
  logic             id_valid;
  logic             ex_valid;
  logic             wb_valid;
  logic [7:0]       id_instr;
  logic [7:0]       ex_instr;
  logic [7:0]       wb_instr;
  logic             pc_src;
  logic             ex_alu;
  logic             wb_reg_wrt;
  logic             stall;
  logic             flush;
  logic             fwd_a;
  logic             fwd_b;
  logic [CNT_W-1:0] stall_cnt;

  // Fetch / observer side
  modport master (
    output instr_valid, instr,
    input  instr_ready, id_valid, ex_valid, wb_valid,
    input  id_instr, ex_instr, wb_instr,
    input  pc_src, ex_alu, wb_reg_wrt,
    input  stall, flush, fwd_a, fwd_b, stall_cnt
  );

  // Issue controller side
  modport slave (
    input  instr_valid, instr,
    output instr_ready, id_valid, ex_valid, wb_valid,
    output id_instr, ex_instr, wb_instr,
    output pc_src, ex_alu, wb_reg_wrt,
    output stall, flush, fwd_a, fwd_b, stall_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_issue_ctrl
// Description : Issue and hazard controller for a 4-stage 8-bit pipeline
//               (IF -> ID -> EX -> WB). Stalls on RAW hazards against ID,
//               inserts BR_BUBBLES issue-blocked cycles after a branch and
//               counts hazard-stall cycles.
//               Optional macro PIPE_FWD_EN: replaces RAW stalls with EX->ID
//               forwarding flags (fwd_a / fwd_b).
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_issue_ctrl #(
  parameter int BR_BUBBLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  pipe_issue_ctrl_if.slave   bus
);

  localparam logic [2:0] BR_LOAD = 3'(BR_BUBBLES);

  logic             id_valid_q, id_valid_d;
  logic             ex_valid_q, ex_valid_d;
  logic             wb_valid_q, wb_valid_d;
  logic [7:0]       id_instr_q, id_instr_d;
  logic [7:0]       ex_instr_q, ex_instr_d;
  logic [7:0]       wb_instr_q, wb_instr_d;
  logic [2:0]       bcnt_q, bcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             fwd_a_q, fwd_a_d;
  logic             fwd_b_q, fwd_b_d;

  logic             hz_w;
  logic             flush_w;
  logic             stall_w;
  logic             ready_w;
  logic             accept_w;
  logic             id_writes_w;

  // ID holds an instruction that will write rd (real, non-branch)
  assign id_writes_w = id_valid_q & ~id_instr_q[7];

`ifdef PIPE_FWD_EN
  // Forwarding covers every ID->IF dependency, so issue never stalls
  assign hz_w = 1'b0;
`else
  assign hz_w = bus.instr_valid & ~bus.instr[7] & id_writes_w &
                ((bus.instr[3:2] == id_instr_q[5:4]) |
                 (bus.instr[1:0] == id_instr_q[5:4]));
`endif

  // Issue gating; everything reads 0 while reset is held
  assign flush_w  = rst_n & (bcnt_q != 3'd0);
  assign stall_w  = rst_n & hz_w & ~flush_w;
  assign ready_w  = rst_n & ~flush_w & ~stall_w;
  assign accept_w = bus.instr_valid & ready_w;

  // Next-state: pipeline shift, bubble counter, stall counter, forward flags
  always_comb begin
    id_valid_d  = accept_w;
    id_instr_d  = accept_w ? bus.instr : 8'h00;
    ex_valid_d  = id_valid_q;
    ex_instr_d  = id_instr_q;
    wb_valid_d  = ex_valid_q;
    wb_instr_d  = ex_instr_q;
    bcnt_d      = bcnt_q;
    stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, stall_w};
    fwd_a_d     = 1'b0;
    fwd_b_d     = 1'b0;

    if (accept_w && bus.instr[7]) begin
      bcnt_d = BR_LOAD;
    end else if (bcnt_q != 3'd0) begin
      bcnt_d = bcnt_q - 3'd1;
    end

`ifdef PIPE_FWD_EN
    // Flags travel with the instruction into ID; a bubble leaves them clear
    if (accept_w && !bus.instr[7] && id_writes_w) begin
      fwd_a_d = (bus.instr[3:2] == id_instr_q[5:4]);
      fwd_b_d = (bus.instr[1:0] == id_instr_q[5:4]);
    end
`endif
  end

  // State registers with synchronous active-low reset discarding in-flight work
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_valid_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      wb_valid_q  <= 1'b0;
      id_instr_q  <= 8'h00;
      ex_instr_q  <= 8'h00;
      wb_instr_q  <= 8'h00;
      bcnt_q      <= 3'd0;
      stall_cnt_q <= '0;
      fwd_a_q     <= 1'b0;
      fwd_b_q     <= 1'b0;
    end else begin
      id_valid_q  <= id_valid_d;
      ex_valid_q  <= ex_valid_d;
      wb_valid_q  <= wb_valid_d;
      id_instr_q  <= id_instr_d;
      ex_instr_q  <= ex_instr_d;
      wb_instr_q  <= wb_instr_d;
      bcnt_q      <= bcnt_d;
      stall_cnt_q <= stall_cnt_d;
      fwd_a_q     <= fwd_a_d;
      fwd_b_q     <= fwd_b_d;
    end
  end

  assign bus.instr_ready = ready_w;
  assign bus.stall       = stall_w;
  assign bus.flush       = flush_w;
  assign bus.id_valid    = id_valid_q;
  assign bus.ex_valid    = ex_valid_q;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.ex_instr    = ex_instr_q;
  assign bus.wb_instr    = wb_instr_q;
  assign bus.pc_src      = rst_n & id_valid_q & id_instr_q[7];
  assign bus.ex_alu      = ex_valid_q & ex_instr_q[6];
  assign bus.wb_reg_wrt  = wb_valid_q & ~wb_instr_q[7];
  assign bus.fwd_a       = fwd_a_q;
  assign bus.fwd_b       = fwd_b_q;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_issue_ctrl
// Description : Self-checking bench for pipe_issue_ctrl (BR_BUBBLES=1,
//               CNT_W=8). Directed stimulus plus a WB-side scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_issue_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  logic [7:0] sb_q[$];

  pipe_issue_ctrl_if #(.CNT_W(8)) bus ();

  pipe_issue_ctrl #(.BR_BUBBLES(1), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted instructions are queued and must leave WB in order
  always @(negedge clk) begin
    logic [8:0] e;
    if (bus.wb_valid === 1'b1) begin
      e = (sb_q.size() > 0) ? {1'b1, sb_q.pop_front()} : 9'h000;
      chk("sb_wb_instr", {23'd0, 1'b1, bus.wb_instr}, {23'd0, e});
      chk("sb_wb_reg_wrt", {31'd0, bus.wb_reg_wrt}, {31'd0, ~e[7]});
    end
    if (rst_n !== 1'b1) sb_q.delete();
    else if (bus.instr_valid === 1'b1 && bus.instr_ready === 1'b1) sb_q.push_back(bus.instr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] prev, nxt;
    int n;
    rst_n = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr = 8'h10;

    // Reset held for two cycles with fetch presenting
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_ready", bus.instr_ready, 0);
      chk("rst_valids", {bus.id_valid, bus.ex_valid, bus.wb_valid}, 0);
      chk("rst_stall_cnt", bus.stall_cnt, 0);
      chk("rst_flush_pc", {bus.flush, bus.stall, bus.pc_src}, 0);
    end
    rst_n = 1'b1;
    bus.instr_valid = 1'b0;
    #1;
    chk("rel_ready", bus.instr_ready, 1);

    // Independent stream 0x10, 0x2F, 0x4C back to back
    bus.instr_valid = 1'b1; bus.instr = 8'h10; #1;
    chk("ind_ready0", bus.instr_ready, 1);
    tick();
    bus.instr = 8'h2F; #1;
    chk("ind_ready1", bus.instr_ready, 1);
    chk("ind_id", bus.id_instr, 8'h10);
    tick();
    bus.instr = 8'h4C; #1;
    chk("ind_ready2", bus.instr_ready, 1);
    chk("ind_ex", bus.ex_instr, 8'h10);
    tick();
    bus.instr_valid = 1'b0; #1;
    chk("ind_wb", bus.wb_instr, 8'h10);
    chk("ind_wb_wrt", bus.wb_reg_wrt, 1);
    chk("ind_ex_alu0", bus.ex_alu, 0);
    tick();
    chk("ind_ex_alu1", bus.ex_alu, 1);
    chk("ind_id_bubble", {bus.id_valid, bus.id_instr}, 0);
    tick(); tick(); tick();

    // RAW hazard: 0x10 (rd=1) then 0x04 (rs1=1)
    bus.instr_valid = 1'b1; bus.instr = 8'h10; #1;
    chk("raw_ready0", bus.instr_ready, 1);
    tick();
    bus.instr = 8'h04; #1;
`ifdef PIPE_FWD_EN
    chk("raw_nostall", {bus.stall, bus.instr_ready}, 2'b01);
    tick();
    bus.instr_valid = 1'b0; #1;
    chk("raw_id", bus.id_instr, 8'h04);
    chk("raw_fwd", {bus.fwd_a, bus.fwd_b}, 2'b10);
    chk("raw_cnt", bus.stall_cnt, 0);
    tick();
    chk("raw_fwd_clr", {bus.fwd_a, bus.fwd_b}, 2'b00);
`else
    chk("raw_stall", {bus.stall, bus.flush, bus.instr_ready}, 3'b100);
    tick();
    #1;
    chk("raw_cnt", bus.stall_cnt, 1);
    chk("raw_ready1", {bus.stall, bus.instr_ready}, 2'b01);
    chk("raw_id_bubble", bus.id_valid, 0);
    tick();
    bus.instr_valid = 1'b0; #1;
    chk("raw_id", bus.id_instr, 8'h04);
    chk("raw_fwd_tied", {bus.fwd_a, bus.fwd_b}, 2'b00);
    exp_cnt = 1;
`endif
    tick(); tick(); tick();

    // Branch 0x85 followed by 0x20 held valid
    bus.instr_valid = 1'b1; bus.instr = 8'h85; #1;
    chk("br_ready0", bus.instr_ready, 1);
    tick();
    bus.instr = 8'h20; #1;
    chk("br_pc_flush", {bus.pc_src, bus.flush, bus.stall, bus.instr_ready}, 4'b1100);
    tick();
    chk("br_ready1", {bus.pc_src, bus.flush, bus.instr_ready}, 3'b001);
    tick();
    bus.instr_valid = 1'b0; #1;
    chk("br_wb", {bus.wb_valid, bus.wb_instr}, 9'h185);
    chk("br_wb_wrt", bus.wb_reg_wrt, 0);
    chk("br_id", bus.id_instr, 8'h20);
    chk("br_cnt_noflush", bus.stall_cnt, exp_cnt);
    tick(); tick(); tick();

`ifndef PIPE_FWD_EN
    // Counter wrap: alternate 0x10 / 0x04 so every issue stalls once
    bus.instr_valid = 1'b1; bus.instr = 8'h10;
    tick();
    prev = 8'h10;
    n = 256 - exp_cnt;
    for (int i = 0; i < n; i++) begin
      nxt = (prev == 8'h10) ? 8'h04 : 8'h10;
      bus.instr = nxt; #1;
      if (i == 0) chk("wrap_stall", {bus.stall, bus.instr_ready}, 2'b10);
      tick();
      exp_cnt = (exp_cnt + 1) % 256;
      if (i == n - 2) chk("wrap_ff", bus.stall_cnt, 8'hFF);
      tick();
      prev = nxt;
    end
    chk("wrap_zero", bus.stall_cnt, 8'h00);
    bus.instr_valid = 1'b0;
    tick(); tick(); tick();
`else
    chk("fwd_cnt_zero", bus.stall_cnt, 0);
`endif

    // Mid-operation reset with a branch in ID and bcnt=1
    bus.instr_valid = 1'b1; bus.instr = 8'h10;
    tick();
    bus.instr = 8'h85; #1;
    chk("mid_ready", bus.instr_ready, 1);
    tick();
    bus.instr_valid = 1'b0; #1;
    chk("mid_pre", {bus.pc_src, bus.flush, bus.ex_valid}, 3'b111);
    rst_n = 1'b0; #1;
    chk("mid_in_rst", {bus.pc_src, bus.flush, bus.stall, bus.instr_ready}, 4'b0000);
    tick();
    rst_n = 1'b1; #1;
    chk("mid_valids", {bus.id_valid, bus.ex_valid, bus.wb_valid}, 0);
    chk("mid_flush_ready", {bus.flush, bus.instr_ready}, 2'b01);
    chk("mid_cnt", bus.stall_cnt, 0);
    bus.instr_valid = 1'b1; bus.instr = 8'h20;
    tick();
    bus.instr_valid = 1'b0; #1;
    chk("mid_accept", {bus.id_valid, bus.id_instr}, 9'h120);
    tick(); tick(); tick(); tick();
    chk("sb_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
